keycode_event_sequencer: RTL and testbench

- Turns the 16-bit USB keycode word (two 8-bit key slots, written by the NIOS USB driver) into an ordered queue of press and release events.
- Filters partially written keycode words with a stability window.
- Diffs each stable snapshot against the previously committed snapshot and queues one event per changed key in a FIFO.
- The FIFO is read over an Avalon-MM slave with a level IRQ. It sits between the keycode PIO export and the game/CPU logic.

---
 rtl/keycode_event_sequencer.sv | 126 ++++++++++++
 tb/tb_keycode_event_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/keycode_event_sequencer.sv
// keycode_event_sequencer: debounces a two-slot USB keycode word and queues press/release events behind an Avalon-MM slave.
module keycode_event_sequencer #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keycode_in,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, REL0, REL1, PRS0, PRS1, COMMIT} state_t;
  state_t state, state_nxt;
  logic [15:0] cand, stable;
  logic [CW-1:0] cnt;
  logic enable, irq_en, overflow;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic push, pop, push_ok, not_empty, full, rd_en, wr_en, settled;
  logic [8:0] push_data;
  logic [31:0] rdata;
  logic [7:0] s0, s1, c0, c1;
  logic unused_bits;
  assign unused_bits = ^writedata[31:2];
  assign {s1, s0} = stable;
  assign {c1, c0} = cand;
  assign settled = keycode_in == cand && cnt == CW'(STABLE_CYCLES - 1) && cand != stable;
  always_comb begin
    state_nxt = state;
    push = 1'b0;
    push_data = '0;
    case (state)
      IDLE: state_nxt = settled ? REL0 : IDLE;
      REL0: begin
        state_nxt = REL1;
        push = s0 != 8'd0 && s0 != c0 && s0 != c1;
        push_data = {1'b0, s0};
      end
      REL1: begin
        state_nxt = PRS0;
        push = s1 != 8'd0 && s1 != c0 && s1 != c1 && s1 != s0;
        push_data = {1'b0, s1};
      end
      PRS0: begin
        state_nxt = PRS1;
        push = c0 != 8'd0 && c0 != s0 && c0 != s1;
        push_data = {1'b1, c0};
      end
      PRS1: begin
        state_nxt = COMMIT;
        push = c1 != 8'd0 && c1 != s0 && c1 != s1 && c1 != c0;
        push_data = {1'b1, c1};
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      push = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cand <= '0;
      stable <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!enable) begin
        cand <= keycode_in;
        stable <= keycode_in;
        cnt <= '0;
      end else if (state == IDLE) begin
        if (keycode_in != cand) begin
          cand <= keycode_in;
          cnt <= '0;
        end else if (cand != stable && cnt != CW'(STABLE_CYCLES - 1)) cnt <= cnt + 1'b1;
      end else if (state == COMMIT) begin
        stable <= cand;
        cnt <= '0;
      end
    end
  end
  assign rd_en = chipselect & read;
  assign wr_en = chipselect & write;
  assign not_empty = count != '0;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign pop = rd_en && address == 2'd0 && not_empty;
  assign push_ok = push && (!full || pop);
  assign rdata = address == 2'd0 ? (not_empty ? {1'b1, 22'b0, mem[rp]} : 32'b0) :
                 address == 2'd1 ? {16'b0, 8'(count), 6'b0, overflow, not_empty} :
                 address == 2'd2 ? {30'b0, irq_en, enable} : {16'b0, stable};
  always_ff @(posedge clk) if (push_ok) mem[wp] <= push_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      enable <= 1'b1;
      irq_en <= 1'b0;
      readdata <= '0;
      irq <= 1'b0;
    end else begin
      if (push_ok) wp <= wp == AW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == AW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      // a dropped event outranks a simultaneous software clear
      overflow <= (push && full && !pop) || (overflow && !(wr_en && address == 2'd1 && writedata[1]));
      if (wr_en && address == 2'd2) begin
        enable <= writedata[0];
        irq_en <= writedata[1];
      end
      irq <= irq_en & not_empty;
      if (rd_en) readdata <= rdata;
    end
  end
endmodule

// File: tb/tb_keycode_event_sequencer.sv
// tb_keycode_event_sequencer: table-driven vectors plus directed corner sequences for the keycode event sequencer.
module tb_keycode_event_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] keycode_in = '0;
  logic chipselect = 1'b0;
  logic [1:0] address = '0;
  logic read = 1'b0;
  logic write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic irq;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [15:0] key;
    int hold;
    logic [1:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];
  keycode_event_sequencer #(.STABLE_CYCLES(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .keycode_in(keycode_in), .chipselect(chipselect),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic hold(input int n);
    repeat (n) tick();
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read = 1'b1;
    address = a;
    tick();
    chipselect = 1'b0;
    read = 1'b0;
    d = readdata;
  endtask
  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write = 1'b1;
    address = a;
    writedata = d;
    tick();
    chipselect = 1'b0;
    write = 1'b0;
    writedata = '0;
  endtask
  task automatic add(input logic [15:0] key, input int h, input logic [1:0] a, input logic [31:0] exp);
    vec_t v;
    v.key = key;
    v.hold = h;
    v.addr = a;
    v.exp = exp;
    vecs.push_back(v);
  endtask
  initial begin
    add(16'h0004, 12, 2'd0, 32'h8000_0104);
    add(16'h0004, 0, 2'd1, 32'h0000_0000);
    add(16'h0004, 0, 2'd3, 32'h0000_0004);
    add(16'h1604, 12, 2'd3, 32'h0000_1604);
    add(16'h0016, 12, 2'd1, 32'h0000_0201);
    add(16'h0016, 0, 2'd0, 32'h8000_0116);
    add(16'h0016, 0, 2'd0, 32'h8000_0004);
    add(16'h0016, 0, 2'd0, 32'h0000_0000);
    add(16'h0016, 0, 2'd3, 32'h0000_0016);
    add(16'h0000, 12, 2'd0, 32'h8000_0016);
    add(16'h0A0B, 12, 2'd0, 32'h8000_010B);
    add(16'h0A0B, 0, 2'd0, 32'h8000_010A);
    add(16'h0C0A, 12, 2'd0, 32'h8000_000B);
    add(16'h0C0A, 0, 2'd0, 32'h8000_010C);
    add(16'h0000, 12, 2'd0, 32'h8000_000A);
    add(16'h0000, 0, 2'd0, 32'h8000_000C);
    add(16'h0707, 12, 2'd1, 32'h0000_0101);
    add(16'h0707, 0, 2'd0, 32'h8000_0107);
    add(16'h0707, 0, 2'd0, 32'h0000_0000);
    add(16'h0000, 12, 2'd1, 32'h0000_0101);
    add(16'h0000, 0, 2'd0, 32'h8000_0007);
    add(16'h0000, 0, 2'd1, 32'h0000_0000);
    hold(2);
    reset = 1'b0;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rd_chk("reset_status", 2'd1, 32'h0);
    rd_chk("reset_control", 2'd2, 32'h1);
    rd_chk("reset_current", 2'd3, 32'h0);
    foreach (vecs[i]) begin
      keycode_in = vecs[i].key;
      hold(vecs[i].hold);
      rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    // glitchy input never settles long enough to be diffed
    for (int i = 0; i < 20; i++) begin
      keycode_in = ((i / 2) % 2 == 0) ? 16'h0004 : 16'h0000;
      tick();
    end
    keycode_in = 16'h0000;
    hold(12);
    rd_chk("toggle_status", 2'd1, 32'h0);
    rd_chk("toggle_current", 2'd3, 32'h0);
    for (int i = 0; i < 10; i++) begin
      keycode_in = (i % 2 == 0) ? 16'(i / 2 + 1) : 16'h0000;
      hold(12);
    end
    rd_chk("ovf_status", 2'd1, 32'h0000_0803);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("ovf_event%0d", i), 2'd0,
             (i % 2 == 0) ? (32'h8000_0100 | 32'(i / 2 + 1)) : (32'h8000_0000 | 32'(i / 2 + 1)));
    rd_chk("ovf_empty_event", 2'd0, 32'h0);
    rd_chk("ovf_sticky", 2'd1, 32'h0000_0002);
    wr(2'd1, 32'h2);
    rd_chk("ovf_cleared", 2'd1, 32'h0);
    wr(2'd2, 32'h3);
    tick();
    check("irq_idle_empty", {31'b0, irq}, 32'h0);
    rd_chk("irq_control", 2'd2, 32'h3);
    keycode_in = 16'h0009;
    for (int i = 0; i < 20 && !irq; i++) tick();
    check("irq_rise", {31'b0, irq}, 32'h1);
    rd_chk("irq_status", 2'd1, 32'h0000_0101);
    rd_chk("irq_pop", 2'd0, 32'h8000_0109);
    check("irq_lag", {31'b0, irq}, 32'h1);
    tick();
    check("irq_fall", {31'b0, irq}, 32'h0);
    keycode_in = 16'h0000;
    hold(12);
    check("irq_release", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    check("irq_mask_lag", {31'b0, irq}, 32'h1);
    tick();
    check("irq_masked", {31'b0, irq}, 32'h0);
    rd_chk("irq_release_event", 2'd0, 32'h8000_0009);
    wr(2'd2, 32'h0);
    keycode_in = 16'h0505;
    hold(12);
    rd_chk("dis_current", 2'd3, 32'h0000_0505);
    rd_chk("dis_status", 2'd1, 32'h0);
    wr(2'd2, 32'h1);
    hold(12);
    rd_chk("reen_status", 2'd1, 32'h0);
    rd_chk("reen_current", 2'd3, 32'h0000_0505);
    rd_chk("reen_control", 2'd2, 32'h1);
    wr(2'd2, 32'h3);
    keycode_in = 16'h0008;
    hold(7);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_readdata", readdata, 32'h0);
    check("mid_reset_irq", {31'b0, irq}, 32'h0);
    rd_chk("mid_reset_current", 2'd3, 32'h0);
    rd_chk("mid_reset_control", 2'd2, 32'h1);
    rd_chk("mid_reset_status", 2'd1, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
